// File: rtl/game_pkg.sv
// Shared types and constants for the two-player ship game controller.
// Holds the state enum, the LED encodings and the default board geometry.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PLACE = 3'd1,
    ST_SYNC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_AIM   = 3'd4,
    ST_FIRE  = 3'd5,
    ST_OVER  = 3'd6
  } GAME_STATE_T;

  localparam logic [3:0] LED_IDLE  = 4'b1000;
  localparam logic [3:0] LED_SETUP = 4'b0100;
  localparam logic [3:0] LED_WAIT  = 4'b0010;
  localparam logic [3:0] LED_TURN  = 4'b0001;
  localparam logic [3:0] LED_OVER  = 4'b1111;

  localparam int DEF_BOARD_N   = 10;
  localparam int DEF_CELL_LOG2 = 5;
  localparam int DEF_ORIGIN_X  = 608;
  localparam int DEF_ORIGIN_Y  = 193;

  function automatic logic [3:0] state_led_f(input GAME_STATE_T st);
    logic [3:0] led;
    case (st)
      ST_IDLE:           led = LED_IDLE;
      ST_PLACE, ST_SYNC: led = LED_SETUP;
      ST_WAIT:           led = LED_WAIT;
      ST_AIM, ST_FIRE:   led = LED_TURN;
      ST_OVER:           led = LED_OVER;
      default:           led = LED_IDLE;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/cell_mapper.sv
// Maps the mouse cursor onto an enemy-board cell with a bounds check.
// Results update once per frame; the last in-board cell is held while outside.
module cell_mapper
  import game_pkg::*;
#(
  parameter int BOARD_N   = DEF_BOARD_N,
  parameter int CELL_LOG2 = DEF_CELL_LOG2,
  parameter int ORIGIN_X  = DEF_ORIGIN_X,
  parameter int ORIGIN_Y  = DEF_ORIGIN_Y,
  localparam int CW = $clog2(BOARD_N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic [11:0]   mouse_xpos,
  input  logic [11:0]   mouse_ypos,
  output logic [CW-1:0] cell_row,
  output logic [CW-1:0] cell_col,
  output logic          cell_valid
);

  localparam logic [12:0] SPAN = 13'(BOARD_N << CELL_LOG2);

  logic [12:0] dx_s;
  logic [12:0] dy_s;
  logic        in_x_s;
  logic        in_y_s;

  // Signed offsets from the board origin; bit 12 set means left of / above the board.
  always_comb begin
    dx_s   = {1'b0, mouse_xpos} - 13'(ORIGIN_X);
    dy_s   = {1'b0, mouse_ypos} - 13'(ORIGIN_Y);
    in_x_s = ~dx_s[12] && (dx_s < SPAN);
    in_y_s = ~dy_s[12] && (dy_s < SPAN);
  end

  // Frame-rate latch of the hovered cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      cell_row   <= {CW{1'b0}};
      cell_col   <= {CW{1'b0}};
      cell_valid <= 1'b0;
    end else if (frame_start) begin
      cell_valid <= in_x_s && in_y_s;
      if (in_x_s && in_y_s) begin
        cell_row <= dy_s[CELL_LOG2 +: CW];
        cell_col <= dx_s[CELL_LOG2 +: CW];
      end
    end
  end

endmodule

// File: rtl/game_turn_ctl.sv
// Game-control FSM: placement, turn hand-off, shot issue with timeout/retry,
// answer handling and win/lose detection for the two-player ship game.
module game_turn_ctl
  import game_pkg::*;
#(
  parameter int BOARD_N        = DEF_BOARD_N,
  parameter int CELL_LOG2      = DEF_CELL_LOG2,
  parameter int ORIGIN_X       = DEF_ORIGIN_X,
  parameter int ORIGIN_Y       = DEF_ORIGIN_Y,
  parameter int SHIP_COUNT     = 11,
  parameter int HITS_TO_WIN    = 17,
  parameter int HIT_KEEPS_TURN = 1,
  parameter int TIMEOUT_FRAMES = 120,
  parameter int MAX_RETRY      = 3,
  localparam int CW = $clog2(BOARD_N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          mouse_left,
  input  logic [11:0]   mouse_xpos,
  input  logic [11:0]   mouse_ypos,
  input  logic          start_button,
  input  logic          first_player,
  input  logic          ship_placed,
  input  logic          remote_ready,
  input  logic          answer_valid,
  input  logic          answer_hit,
  input  logic          rx_shot_valid,
  input  logic          rx_shot_hit,
  output logic [CW-1:0] cell_row,
  output logic [CW-1:0] cell_col,
  output logic          cell_valid,
  output logic          pick_ship,
  output logic          fire_req,
  output logic          my_turn,
  output logic          game_over,
  output logic          win,
  output logic          link_err,
  output logic [3:0]    state_led
);

  localparam int NCELL = BOARD_N * BOARD_N;
  localparam int MW    = $clog2(NCELL);
  localparam int SCW   = $clog2(SHIP_COUNT + 1);
  localparam int HCW   = $clog2(HITS_TO_WIN + 1);
  localparam int FCW   = $clog2(TIMEOUT_FRAMES + 1);
  localparam int RCW   = $clog2(MAX_RETRY + 1);

  GAME_STATE_T      state_r, state_nxt_s;
  logic [NCELL-1:0] shot_map_r, shot_map_nxt_s;
  logic [SCW-1:0]   ship_cnt_r, ship_cnt_nxt_s;
  logic [HCW-1:0]   my_hits_r, my_hits_nxt_s;
  logic [HCW-1:0]   opp_hits_r, opp_hits_nxt_s;
  logic [FCW-1:0]   frame_cnt_r, frame_cnt_nxt_s;
  logic [RCW-1:0]   retry_r, retry_nxt_s;
  logic [CW-1:0]    shot_row_r, shot_row_nxt_s;
  logic [CW-1:0]    shot_col_r, shot_col_nxt_s;
  logic             mouse_left_d_r;
  logic             click_s;
  logic             fire_nxt_s;
  logic             win_nxt_s;
  logic             link_err_nxt_s;
  logic [CW-1:0]    map_row_s;
  logic [CW-1:0]    map_col_s;
  logic             map_valid_s;
  logic [MW-1:0]    idx_s;

  cell_mapper #(
    .BOARD_N   (BOARD_N),
    .CELL_LOG2 (CELL_LOG2),
    .ORIGIN_X  (ORIGIN_X),
    .ORIGIN_Y  (ORIGIN_Y)
  ) u_cell_mapper (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .mouse_xpos  (mouse_xpos),
    .mouse_ypos  (mouse_ypos),
    .cell_row    (map_row_s),
    .cell_col    (map_col_s),
    .cell_valid  (map_valid_s)
  );

  // Click edge detect and flat shot-map index of the hovered cell.
  always_comb begin
    click_s = mouse_left & ~mouse_left_d_r;
    idx_s   = MW'(map_row_s) * MW'(BOARD_N) + MW'(map_col_s);
  end

  // Next-state, counter and event logic.
  always_comb begin
    state_nxt_s     = state_r;
    shot_map_nxt_s  = shot_map_r;
    ship_cnt_nxt_s  = ship_cnt_r;
    my_hits_nxt_s   = my_hits_r;
    opp_hits_nxt_s  = opp_hits_r;
    frame_cnt_nxt_s = frame_cnt_r;
    retry_nxt_s     = retry_r;
    shot_row_nxt_s  = shot_row_r;
    shot_col_nxt_s  = shot_col_r;
    fire_nxt_s      = 1'b0;
    win_nxt_s       = win;
    link_err_nxt_s  = link_err;

    case (state_r)
      ST_IDLE: begin
        if (start_button) state_nxt_s = ST_PLACE;
        else              state_nxt_s = ST_IDLE;
      end
      ST_PLACE: begin
        if (ship_placed && (ship_cnt_r != SCW'(SHIP_COUNT))) ship_cnt_nxt_s = ship_cnt_r + SCW'(1);
        else                                                 ship_cnt_nxt_s = ship_cnt_r;
        if (ship_cnt_nxt_s == SCW'(SHIP_COUNT)) state_nxt_s = ST_SYNC;
        else                                    state_nxt_s = ST_PLACE;
      end
      ST_SYNC: begin
        if (remote_ready) state_nxt_s = first_player ? ST_AIM : ST_WAIT;
        else              state_nxt_s = ST_SYNC;
      end
      ST_WAIT: begin
        if (rx_shot_valid) begin
          if (rx_shot_hit && (opp_hits_r != HCW'(HITS_TO_WIN))) opp_hits_nxt_s = opp_hits_r + HCW'(1);
          else                                                  opp_hits_nxt_s = opp_hits_r;
          if (opp_hits_nxt_s == HCW'(HITS_TO_WIN)) begin
            state_nxt_s = ST_OVER;
            win_nxt_s   = 1'b0;
          end else if (rx_shot_hit && (HIT_KEEPS_TURN != 0)) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_AIM;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_AIM: begin
        if (click_s && map_valid_s && !shot_map_r[idx_s]) begin
          fire_nxt_s            = 1'b1;
          shot_map_nxt_s[idx_s] = 1'b1;
          shot_row_nxt_s        = map_row_s;
          shot_col_nxt_s        = map_col_s;
          frame_cnt_nxt_s       = {FCW{1'b0}};
          retry_nxt_s           = {RCW{1'b0}};
          state_nxt_s           = ST_FIRE;
        end else begin
          state_nxt_s = ST_AIM;
        end
      end
      ST_FIRE: begin
        // An answer arriving with the timeout frame takes priority over a re-issue.
        if (answer_valid) begin
          if (answer_hit && (my_hits_r != HCW'(HITS_TO_WIN))) my_hits_nxt_s = my_hits_r + HCW'(1);
          else                                                my_hits_nxt_s = my_hits_r;
          if (my_hits_nxt_s == HCW'(HITS_TO_WIN)) begin
            state_nxt_s = ST_OVER;
            win_nxt_s   = 1'b1;
          end else if (answer_hit && (HIT_KEEPS_TURN != 0)) begin
            state_nxt_s = ST_AIM;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else if (frame_start) begin
          if (frame_cnt_r == FCW'(TIMEOUT_FRAMES - 1)) begin
            if (retry_r == RCW'(MAX_RETRY)) begin
              link_err_nxt_s = 1'b1;
              win_nxt_s      = 1'b0;
              state_nxt_s    = ST_OVER;
            end else begin
              fire_nxt_s      = 1'b1;
              frame_cnt_nxt_s = {FCW{1'b0}};
              retry_nxt_s     = retry_r + RCW'(1);
              state_nxt_s     = ST_FIRE;
            end
          end else begin
            frame_cnt_nxt_s = frame_cnt_r + FCW'(1);
            state_nxt_s     = ST_FIRE;
          end
        end else begin
          state_nxt_s = ST_FIRE;
        end
      end
      ST_OVER: begin
        state_nxt_s = ST_OVER;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs follow the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      shot_map_r     <= {NCELL{1'b0}};
      ship_cnt_r     <= {SCW{1'b0}};
      my_hits_r      <= {HCW{1'b0}};
      opp_hits_r     <= {HCW{1'b0}};
      frame_cnt_r    <= {FCW{1'b0}};
      retry_r        <= {RCW{1'b0}};
      shot_row_r     <= {CW{1'b0}};
      shot_col_r     <= {CW{1'b0}};
      mouse_left_d_r <= 1'b0;
      cell_row       <= {CW{1'b0}};
      cell_col       <= {CW{1'b0}};
      cell_valid     <= 1'b0;
      pick_ship      <= 1'b0;
      fire_req       <= 1'b0;
      my_turn        <= 1'b0;
      game_over      <= 1'b0;
      win            <= 1'b0;
      link_err       <= 1'b0;
      state_led      <= LED_IDLE;
    end else begin
      state_r        <= state_nxt_s;
      shot_map_r     <= shot_map_nxt_s;
      ship_cnt_r     <= ship_cnt_nxt_s;
      my_hits_r      <= my_hits_nxt_s;
      opp_hits_r     <= opp_hits_nxt_s;
      frame_cnt_r    <= frame_cnt_nxt_s;
      retry_r        <= retry_nxt_s;
      shot_row_r     <= shot_row_nxt_s;
      shot_col_r     <= shot_col_nxt_s;
      mouse_left_d_r <= mouse_left;
      // While a shot is outstanding the cell outputs name the target, not the cursor.
      cell_row       <= (state_nxt_s == ST_FIRE) ? shot_row_nxt_s : map_row_s;
      cell_col       <= (state_nxt_s == ST_FIRE) ? shot_col_nxt_s : map_col_s;
      cell_valid     <= map_valid_s;
      pick_ship      <= (state_nxt_s == ST_PLACE) && mouse_left;
      fire_req       <= fire_nxt_s;
      my_turn        <= (state_nxt_s == ST_AIM) || (state_nxt_s == ST_FIRE);
      game_over      <= (state_nxt_s == ST_OVER);
      win            <= win_nxt_s;
      link_err       <= link_err_nxt_s;
      state_led      <= state_led_f(state_nxt_s);
    end
  end

endmodule

// File: doc/game_turn_ctl.md
Name: game_turn_ctl

Overview:
- Parametrised game-control FSM for the two-player ship game: placement phase, turn hand-off, shot issue, answer handshake, win/lose detection.
- Sits between the mouse/VGA timing front-end and the board-memory / inter-board link blocks.
- Generalises the fixed 10x10, 32-px, 11-ship controller in several ways:
  - configurable board geometry;
  - bounds-checked cell mapping;
  - shot-history map (no repeat shots);
  - answer timeout with retry;
  - hit-keeps-turn mode;
  - end-of-game detection.

Parameters:
- BOARD_N, 10, cells per board side (2..16)
- CELL_LOG2, 5, log2 of cell size in pixels (32 px)
- ORIGIN_X, 608, pixel x of enemy-board column 0
- ORIGIN_Y, 193, pixel y of enemy-board row 0
- SHIP_COUNT, 11, placement clicks required to leave PLACE
- HITS_TO_WIN, 17, hits on one side that end the game
- HIT_KEEPS_TURN, 1, 1 = a hit grants another shot; 0 = strict alternation
- TIMEOUT_FRAMES, 120, frames to wait for an answer before re-issuing a shot
- MAX_RETRY, 3, re-issues before declaring link error

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- frame_start  in  1  one-clk strobe at hcount==0 && vcount==0
- mouse_left  in  1  left button level
- mouse_xpos  in  12  cursor x
- mouse_ypos  in  12  cursor y
- start_button  in  1  debounced start level
- first_player  in  1  1 = this board shoots first
- ship_placed  in  1  pulse from placement logic, one per accepted ship
- remote_ready  in  1  level: opponent finished placement
- answer_valid  in  1  pulse: opponent answered our shot
- answer_hit  in  1  qualifies answer_valid
- rx_shot_valid  in  1  pulse: opponent shot at us
- rx_shot_hit  in  1  qualifies rx_shot_valid (local board lookup result)
- cell_row  out  CW  hovered row, CW=$clog2(BOARD_N)
- cell_col  out  CW  hovered column
- cell_valid  out  1  cursor inside enemy board
- pick_ship  out  1  placement click request (PLACE only)
- fire_req  out  1  one-clk pulse: shot at {cell_row,cell_col}
- my_turn  out  1  high in AIM/FIRE
- game_over  out  1  high in OVER
- win  out  1  valid when game_over
- link_err  out  1  sticky: retries exhausted
- state_led  out  4  one-hot state display

Behaviour:
- Reset: all outputs 0, state IDLE, shot_map cleared, counters cleared, state_led=4'b1000.
- Cell mapping: dx=xpos-ORIGIN_X, dy=ypos-ORIGIN_Y (13-bit signed); cell = d>>CELL_LOG2.
  - cell_valid=1 only when 0<=dx<BOARD_N<<CELL_LOG2 and likewise dy; otherwise cell_row/col hold their last valid value.
  - Registered on frame_start only, i.e. 1 frame latency.
- Click: rising edge of mouse_left (registered compare); all other events are evaluated every clk.
- States:
  - IDLE: start_button -> PLACE.
  - PLACE: pick_ship=mouse_left; each ship_placed increments ship_cnt; at ship_cnt==SHIP_COUNT -> SYNC.
  - SYNC: remote_ready -> AIM if first_player, else WAIT.
  - WAIT: on rx_shot_valid, opp_hits += rx_shot_hit. If opp_hits reaches HITS_TO_WIN -> OVER with win=0. Else, if rx_shot_hit && HIT_KEEPS_TURN, stay in WAIT; otherwise -> AIM.
  - AIM: click && cell_valid && !shot_map[cell] -> fire_req pulse, set shot_map bit, latch cell, -> FIRE. Clicks on invalid or already-shot cells are ignored.
  - FIRE: on answer_valid, my_hits += answer_hit. If my_hits reaches HITS_TO_WIN -> OVER with win=1. Else, if answer_hit && HIT_KEEPS_TURN -> AIM; otherwise -> WAIT.
    - Frame counter runs in FIRE; at TIMEOUT_FRAMES, re-pulse fire_req with the latched cell, clear the counter, retry++.
    - When retry==MAX_RETRY, set link_err -> OVER with win=0.
  - OVER: hold until rst.
- state_led: IDLE/PLACE/SYNC=1000/0100, WAIT=0010, AIM/FIRE=0001, OVER=1111.
- Simultaneous events:
  - answer_valid and timeout in the same clk: answer wins, no re-issue.
  - rx_shot_valid outside WAIT: ignored.
  - answer_valid outside FIRE: ignored.
- Counters saturate; they never wrap.
- rst mid-game: immediate return to IDLE; shot_map cleared in the same clk.

Decomposition:
- Shared package (game_pkg): state enum GAME_STATE_T, LED encodings, default board constants.
- Sub-module cell_mapper: the mouse-to-cell arithmetic plus bounds check, latched on frame_start.
- shot_map: BOARD_N*BOARD_N-bit register, kept in the top module.

Test Plan:
- Mapping: mouse (608,193) -> row0/col0, valid=1; (927,512) -> row9/col9, valid=1; (607,300) -> valid=0, last row/col held.
- Flow: start, 11 ship_placed pulses, remote_ready, first_player=1 -> AIM within 1 clk; click at (640,225) -> fire_req once with row1/col1, state FIRE.
- Repeat shot: after a miss and a return to AIM, clicking cell 1,1 again -> no fire_req; a different cell fires.
- Timeout: no answer for 120 frames -> second fire_req with the same cell; after 3 retries -> link_err=1, game_over=1, win=0.
- Win: 17 answer_hit=1 answers with HIT_KEEPS_TURN=1 -> never leaves AIM/FIRE; game_over=1, win=1; with HIT_KEEPS_TURN=0, each answer -> WAIT.
- Reset during FIRE -> IDLE, all outputs 0, previously shot cell is clickable again.
